// File: rtl/nba_pkg.sv
// Shared types and the bank hash for the neighbor bank arbiter.
// Entry fields are sized for the widest supported geometry; instances zero-extend into them.
package nba_pkg;

  localparam int BANK_W = 5;
  localparam int RW     = 7;
  localparam int MAX_RW = 16;
  localparam int MAX_DW = 32;

  typedef struct packed {
    logic              valid;
    logic [MAX_RW-1:0] row;
    logic [MAX_RW-1:0] col;
    logic [MAX_DW-1:0] value;
  } entry_t;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_e;

  // Bank counts are powers of two, so both modulo steps reduce to one final mask.
  function automatic logic [MAX_RW-1:0] bank_of(input logic [MAX_RW-1:0] row,
                                                input logic [MAX_RW-1:0] col,
                                                input int unsigned       row_shift,
                                                input int unsigned       bank_count);
    logic [47:0] prod;
    logic [47:0] sum;
    prod = {32'd0, row} * {16'd0, row_shift};
    sum  = prod + {32'd0, col};
    return sum[MAX_RW-1:0] & MAX_RW'(bank_count - 1);
  endfunction

endpackage

// File: rtl/nba_alloc.sv
// Combinational single-pass bank allocator; lower port index wins a contested bank.
module nba_alloc
  import nba_pkg::*;
#(
  parameter int BANK_COUNT = 32,
  parameter int PORT_COUNT = 8,
  parameter int ROW_SHIFT  = 3,
  localparam int BW = $clog2(BANK_COUNT),
  localparam int PW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1
) (
  input  entry_t [PORT_COUNT-1:0]         cand_i,
  input  logic   [BANK_COUNT-1:0]         bank_busy_i,
  output logic   [PORT_COUNT-1:0]         grant_o,
  output logic   [BANK_COUNT-1:0]         claim_o,
  output logic   [BANK_COUNT-1:0][PW-1:0] sel_o
);

  logic [PORT_COUNT-1:0][BW-1:0] bidx;
  logic                          unused_cand;

  assign unused_cand = ^cand_i;

  always_comb begin
    for (int p = 0; p < PORT_COUNT; p++) begin
      bidx[p] = BW'(bank_of(cand_i[p].row, cand_i[p].col, ROW_SHIFT, BANK_COUNT));
    end
  end

  always_comb begin
    grant_o = '0;
    claim_o = '0;
    sel_o   = '0;
    for (int p = 0; p < PORT_COUNT; p++) begin
      if (cand_i[p].valid && !bank_busy_i[bidx[p]] && !claim_o[bidx[p]]) begin
        grant_o[p]        = 1'b1;
        claim_o[bidx[p]]  = 1'b1;
        sel_o[bidx[p]]    = PW'(p);
      end
    end
  end

endmodule

// File: rtl/neighbor_bank_arbiter.sv
// Bank-conflict arbiter: one write per bank per cycle, conflicting entries parked until drained.
// Optional NBA_STATS_EN adds a saturating conflict_count of deferred entries.
module neighbor_bank_arbiter
  import nba_pkg::*;
#(
  parameter int BANK_COUNT = 1 << BANK_W,
  parameter int TILE_SIZE  = 1 << RW,
  parameter int PORT_COUNT = 8,
  parameter int ROW_SHIFT  = 3,
  parameter int DATA_W     = 8
) (
  input  logic                                            clk,
  input  logic                                            reset_n,
  input  logic [PORT_COUNT-1:0]                           in_valid,
  input  logic [PORT_COUNT-1:0][$clog2(TILE_SIZE)-1:0]    in_row,
  input  logic [PORT_COUNT-1:0][$clog2(TILE_SIZE)-1:0]    in_col,
  input  logic [PORT_COUNT-1:0][DATA_W-1:0]               in_value,
  output logic                                            in_ready,
  input  logic [BANK_COUNT-1:0]                           bank_busy,
  output logic [BANK_COUNT-1:0]                           buf_we,
  output logic [BANK_COUNT-1:0][$clog2(TILE_SIZE)-1:0]    buf_row,
  output logic [BANK_COUNT-1:0][$clog2(TILE_SIZE)-1:0]    buf_col,
  output logic [BANK_COUNT-1:0][DATA_W-1:0]               buf_data,
  output logic                                            busy
`ifdef NBA_STATS_EN
  ,output logic [15:0]                                    conflict_count
`endif
);

  localparam int ARW = $clog2(TILE_SIZE);
  localparam int PW  = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

  state_e                           state_q;
  entry_t [PORT_COUNT-1:0]          pend_q, pend_d, cand;
  logic   [PORT_COUNT-1:0]          pend_vld_d, grant;
  logic   [BANK_COUNT-1:0]          claim;
  logic   [BANK_COUNT-1:0][PW-1:0]  sel;

  logic [BANK_COUNT-1:0]            buf_we_q, buf_we_d;
  logic [BANK_COUNT-1:0][ARW-1:0]   buf_row_q, buf_row_d, buf_col_q, buf_col_d;
  logic [BANK_COUNT-1:0][DATA_W-1:0] buf_data_q, buf_data_d;

  assign busy     = (state_q == DRAIN);
  assign in_ready = ~busy;
  assign buf_we   = buf_we_q;
  assign buf_row  = buf_row_q;
  assign buf_col  = buf_col_q;
  assign buf_data = buf_data_q;

  // While draining only the pending register competes; live inputs are ignored.
  always_comb begin
    cand = '0;
    for (int p = 0; p < PORT_COUNT; p++) begin
      if (busy) begin
        cand[p] = pend_q[p];
      end else begin
        cand[p].valid = in_valid[p];
        cand[p].row   = MAX_RW'(in_row[p]);
        cand[p].col   = MAX_RW'(in_col[p]);
        cand[p].value = MAX_DW'(in_value[p]);
      end
    end
  end

  nba_alloc #(
    .BANK_COUNT (BANK_COUNT),
    .PORT_COUNT (PORT_COUNT),
    .ROW_SHIFT  (ROW_SHIFT)
  ) u_alloc (
    .cand_i      (cand),
    .bank_busy_i (bank_busy),
    .grant_o     (grant),
    .claim_o     (claim),
    .sel_o       (sel)
  );

  always_comb begin
    pend_d     = cand;
    pend_vld_d = '0;
    for (int p = 0; p < PORT_COUNT; p++) begin
      pend_vld_d[p]   = cand[p].valid & ~grant[p];
      pend_d[p].valid = pend_vld_d[p];
    end
  end

  always_comb begin
    buf_we_d   = claim;
    buf_row_d  = '0;
    buf_col_d  = '0;
    buf_data_d = '0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      if (claim[b]) begin
        buf_row_d[b]  = cand[sel[b]].row[ARW-1:0];
        buf_col_d[b]  = cand[sel[b]].col[ARW-1:0];
        buf_data_d[b] = cand[sel[b]].value[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      buf_we_q   <= '0;
      buf_row_q  <= '0;
      buf_col_q  <= '0;
      buf_data_q <= '0;
    end else begin
      state_q    <= (|pend_vld_d) ? DRAIN : IDLE;
      pend_q     <= pend_d;
      buf_we_q   <= buf_we_d;
      buf_row_q  <= buf_row_d;
      buf_col_q  <= buf_col_d;
      buf_data_q <= buf_data_d;
    end
  end

`ifdef NBA_STATS_EN
  localparam int CW = $clog2(PORT_COUNT + 1);

  logic [15:0]   cnt_q, cnt_d;
  logic [CW-1:0] ndef;
  logic [16:0]   cnt_sum;

  always_comb begin
    ndef = '0;
    for (int p = 0; p < PORT_COUNT; p++) begin
      ndef = ndef + CW'(pend_vld_d[p]);
    end
    cnt_sum = {1'b0, cnt_q} + 17'(ndef);
    cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign conflict_count = cnt_q;
`endif

endmodule

// File: tb/tb_neighbor_bank_arbiter.sv
// Directed bench for neighbor_bank_arbiter at default parameters (bank = (col + 3*row) mod 32).
module tb_neighbor_bank_arbiter;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [7:0]           in_valid;
  logic [7:0][6:0]      in_row, in_col;
  logic [7:0][7:0]      in_value;
  logic                 in_ready;
  logic [31:0]          bank_busy;
  logic [31:0]          buf_we;
  logic [31:0][6:0]     buf_row, buf_col;
  logic [31:0][7:0]     buf_data;
  logic                 busy;
`ifdef NBA_STATS_EN
  logic [15:0]          conflict_count;
  logic [15:0]          cc_start;
`endif

  int checks = 0;
  int failures = 0;

  neighbor_bank_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_row    (in_row),
    .in_col    (in_col),
    .in_value  (in_value),
    .in_ready  (in_ready),
    .bank_busy (bank_busy),
    .buf_we    (buf_we),
    .buf_row   (buf_row),
    .buf_col   (buf_col),
    .buf_data  (buf_data),
    .busy      (busy)
`ifdef NBA_STATS_EN
    ,.conflict_count (conflict_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      vld;
    logic [7:0][6:0] row;
    logic [7:0][6:0] col;
    logic [7:0][7:0] val;
    logic [31:0]     bbusy;
    logic [31:0]     exp_we;
    logic            exp_busy;
    int              cb;
    logic [6:0]      crow;
    logic [6:0]      ccol;
    logic [7:0]      cdata;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = '0;
    in_row   = '0;
    in_col   = '0;
    in_value = '0;
  endtask

  task automatic set_port(input int p, input logic [6:0] r, input logic [6:0] c, input logic [7:0] v);
    in_valid[p] = 1'b1;
    in_row[p]   = r;
    in_col[p]   = c;
    in_value[p] = v;
  endtask

  task automatic vport(input int i, input int p, input logic [6:0] r, input logic [6:0] c, input logic [7:0] v);
    tbl[i].vld[p] = 1'b1;
    tbl[i].row[p] = r;
    tbl[i].col[p] = c;
    tbl[i].val[p] = v;
  endtask

  task automatic vexp(input int i, input logic [31:0] we, input logic bsy, input int cb,
                      input logic [6:0] r, input logic [6:0] c, input logic [7:0] d);
    tbl[i].exp_we   = we;
    tbl[i].exp_busy = bsy;
    tbl[i].cb       = cb;
    tbl[i].crow     = r;
    tbl[i].ccol     = c;
    tbl[i].cdata    = d;
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("drain_done", busy, 1'b0);
  endtask

  initial begin
    logic seen;

    for (int i = 0; i < 7; i++) begin
      tbl[i].vld = '0; tbl[i].row = '0; tbl[i].col = '0; tbl[i].val = '0;
      tbl[i].bbusy = '0;
    end
    vport(0, 0, 7'd0, 7'd5, 8'h11);  vport(0, 1, 7'd0, 7'd6, 8'h22);
    vexp(0, 32'h0000_0060, 1'b0, 5, 7'd0, 7'd5, 8'h11);
    vport(1, 0, 7'd0, 7'd5, 8'h33);  vport(1, 1, 7'd1, 7'd2, 8'h44);
    vexp(1, 32'h0000_0020, 1'b1, 5, 7'd0, 7'd5, 8'h33);
    vport(2, 0, 7'd0, 7'd6, 8'h55);  vport(2, 1, 7'd0, 7'd7, 8'h66);
    tbl[2].bbusy = 32'h0000_0040;
    vexp(2, 32'h0000_0080, 1'b1, 7, 7'd0, 7'd7, 8'h66);
    vport(3, 7, 7'd10, 7'd1, 8'h77);
    vexp(3, 32'h8000_0000, 1'b0, 31, 7'd10, 7'd1, 8'h77);
    vport(4, 2, 7'd127, 7'd127, 8'hAB); vport(4, 3, 7'd20, 7'd4, 8'hCD);
    vexp(4, 32'h1000_0001, 1'b0, 28, 7'd127, 7'd127, 8'hAB);
    vexp(5, 32'h0, 1'b0, 0, 7'd0, 7'd0, 8'h00);
    for (int p = 0; p < 8; p++) vport(6, p, 7'd0, 7'(p), 8'(8'h60 + p));
    vexp(6, 32'h0000_00FF, 1'b0, 3, 7'd0, 7'd3, 8'h63);

    clear_in();
    bank_busy = '0;
    #12;
    chk("reset_we", buf_we, 32'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", in_ready, 1'b1);
    chk("reset_data", buf_data, '0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      in_valid  = tbl[i].vld;
      in_row    = tbl[i].row;
      in_col    = tbl[i].col;
      in_value  = tbl[i].val;
      bank_busy = tbl[i].bbusy;
      tick();
      chk($sformatf("v%0d_we", i), buf_we, tbl[i].exp_we);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].exp_busy);
      chk($sformatf("v%0d_row", i), buf_row[tbl[i].cb], tbl[i].crow);
      chk($sformatf("v%0d_col", i), buf_col[tbl[i].cb], tbl[i].ccol);
      chk($sformatf("v%0d_data", i), buf_data[tbl[i].cb], tbl[i].cdata);
      clear_in();
      bank_busy = '0;
      drain();
    end

    // two-way conflict on bank 5
    set_port(0, 7'd0, 7'd5, 8'h33);
    set_port(1, 7'd1, 7'd2, 8'h44);
    tick();
    clear_in();
    chk("c2_first_data", buf_data[5], 8'h33);
    chk("c2_busy", busy, 1'b1);
    chk("c2_ready_low", in_ready, 1'b0);
    tick();
    chk("c2_second_we", buf_we[5], 1'b1);
    chk("c2_second_row", buf_row[5], 7'd1);
    chk("c2_second_col", buf_col[5], 7'd2);
    chk("c2_second_data", buf_data[5], 8'h44);
    tick();
    chk("c2_ready_again", in_ready, 1'b1);
    chk("c2_we_off", buf_we[5], 1'b0);

    // eight-way conflict on bank 0
`ifdef NBA_STATS_EN
    cc_start = conflict_count;
`endif
    set_port(0, 7'd0, 7'd0, 8'hA0);
    for (int p = 1; p < 8; p++) set_port(p, 7'(p), 7'(32 - 3 * p), 8'(8'hA0 + p));
    tick();
    clear_in();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      chk($sformatf("c8_we_%0d", k), buf_we[0], 1'b1);
      chk($sformatf("c8_data_%0d", k), buf_data[0], 8'(8'hA0 + k));
      chk($sformatf("c8_row_%0d", k), buf_row[0], 7'(k));
      chk($sformatf("c8_busy_%0d", k), busy, (k < 7));
    end
    tick();
    chk("c8_idle_we", buf_we[0], 1'b0);
    chk("c8_idle_busy", busy, 1'b0);
`ifdef NBA_STATS_EN
    chk("c8_conflict_count", conflict_count - cc_start, 16'd28);
`endif

    // bank 5 stalled for three allocation passes
    bank_busy[5] = 1'b1;
    set_port(0, 7'd0, 7'd5, 8'h5A);
    set_port(1, 7'd0, 7'd9, 8'h99);
    tick();
    clear_in();
    chk("stall_we5_c1", buf_we[5], 1'b0);
    chk("stall_we9_c1", buf_we[9], 1'b1);
    chk("stall_data9", buf_data[9], 8'h99);
    chk("stall_busy", busy, 1'b1);
    tick();
    chk("stall_we5_c2", buf_we[5], 1'b0);
    tick();
    chk("stall_we5_c3", buf_we[5], 1'b0);
    bank_busy[5] = 1'b0;
    tick();
    chk("stall_we5_rel", buf_we[5], 1'b1);
    chk("stall_data5", buf_data[5], 8'h5A);
    chk("stall_idle", busy, 1'b0);

    // backpressure: second group held off until ready
    set_port(0, 7'd0, 7'd5, 8'h10);
    set_port(1, 7'd1, 7'd2, 8'h20);
    tick();
    clear_in();
    chk("bp_busy", busy, 1'b1);
    set_port(0, 7'd0, 7'd12, 8'hC3);
    tick();
    chk("bp_drain_data", buf_data[5], 8'h20);
    chk("bp_not_captured", buf_we[12], 1'b0);
    chk("bp_ready", in_ready, 1'b1);
    tick();
    chk("bp_write_we", buf_we[12], 1'b1);
    chk("bp_write_data", buf_data[12], 8'hC3);
    clear_in();
    tick();
    chk("bp_write_once", buf_we[12], 1'b0);

    // reset in the middle of a drain
    set_port(0, 7'd0, 7'd5, 8'h77);
    set_port(1, 7'd1, 7'd2, 8'h88);
    tick();
    clear_in();
    chk("rst_pre_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_we_cleared", buf_we, 32'h0);
    chk("rst_busy_cleared", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    #2;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (buf_we[5]) seen = 1'b1;
    end
    chk("rst_no_stale_write", seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neighbor_bank_arbiter.md
# neighbor_bank_arbiter

- Parametrised bank-conflict arbiter between the neighbor-tile input links and the banked input-activation buffer.
- Accepts a group of up to PORT_COUNT (row, column, value) writes per cycle and maps each to a bank.
- Issues at most one write per bank per cycle and holds conflicting entries in a pending register until they drain.
- Adds ready/valid backpressure and per-bank stall inputs, and generalises port count and bank-hash stride.

## Interface
- BANK_COUNT, 32, buffer banks; power of two, ≥ 2
- TILE_SIZE, 128, tile dimension; row/column width RW = $clog2(TILE_SIZE)
- PORT_COUNT, 8, neighbor input ports, 1..16
- ROW_SHIFT, 3, bank-hash row stride
- DATA_W, 8, value width
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- in_valid  in  PORT_COUNT  per-port entry valid
- in_row / in_col  in  PORT_COUNT×RW  entry coordinates
- in_value  in  PORT_COUNT×DATA_W  entry data
- in_ready  out  1  group accepted when in_ready && |in_valid
- bank_busy  in  BANK_COUNT  bank cannot take a write this cycle
- buf_we  out  BANK_COUNT  registered bank write enable
- buf_row / buf_col  out  BANK_COUNT×RW  registered write address
- buf_data  out  BANK_COUNT×DATA_W  registered write data
- busy  out  1  pending entries outstanding
- conflict_count  out  16  present only with NBA_STATS_EN

## Operation
- Bank function: bank = (col + (row*ROW_SHIFT) mod BANK_COUNT) mod BANK_COUNT.
  - Compute the product at RW+$clog2(ROW_SHIFT)+1 bits, then take the low $clog2(BANK_COUNT) bits.
- Candidate set source:
  - pending register when busy = 1;
  - live inputs when in_valid && in_ready.
- Allocation is one combinational pass, port 0 = highest priority.
  - An entry is granted if its bank is not busy (bank_busy = 0) and not already claimed this pass.
  - All other entries are deferred.
- Granted entries load buf_* for their bank on the next edge.
  - Non-granted banks: buf_we = 0; buf_row, buf_col and buf_data = 0.
- Deferred entries are written into the pending register: value, row, column and valid bit.
  - Deferred pending entries keep their stored values; only the valid bit changes.
- States: IDLE (pending empty) and DRAIN (pending non-empty).
  - IDLE → DRAIN when any entry of the accepted group is deferred.
  - DRAIN → IDLE when the last pending entry is granted.
- in_ready = ~busy, combinational from state. Inputs presented while in_ready = 0 are ignored and not captured.
- Without bank_busy, a group drains in at most PORT_COUNT cycles. With bank_busy there is no bound.
- in_valid with in_ready = 1 and all valid entries granted: stays IDLE, ready again next cycle.

## Timing
- Latency: accept edge → buf_we high on that same edge's registered output, visible the cycle after accept. Deferred entries appear ≥ 1 cycle later.
- Back-to-back groups without conflicts give full throughput: one group per cycle.
- Reset (asynchronous, any state, including mid-drain):
  - buf_we, buf_row, buf_col, buf_data = 0;
  - pending valid = 0, state IDLE, busy = 0;
  - in_ready = 1 once reset_n is released (it is also 1 during reset, but nothing is captured);
  - conflict_count = 0;
  - pending entries are discarded.
- bank_busy is sampled in the allocation cycle only. A bank_busy change mid-drain takes effect in the next pass.

## Configuration
- NBA_STATS_EN defined:
  - conflict_count port exists;
  - increments by the number of deferred entries each cycle, saturating at 16'hFFFF.
- NBA_STATS_EN undefined: port and counter are absent. All other behaviour is identical.

## Structure
- Package nba_pkg holds:
  - function bank_of(row, col), parametrised through package parameters or passed widths;
  - typedef entry_t {valid, row, col, value};
  - localparams BANK_W and RW.
- Sub-module nba_alloc: purely combinational priority allocator.
  - Inputs: candidate entry_t array and bank_busy.
  - Outputs: grant vector and per-bank selected port index.
- Top level holds the pending register, state, output registers and stats.

## Test plan
All cases use the default parameters.
- **No conflict.** Port 0 (r0,c5) and port 1 (r0,c6), values 8'h11/8'h22 → next cycle buf_we[5] = buf_we[6] = 1 with those data; busy stays 0.
- **Two-way conflict.** Port 0 (r0,c5) and port 1 (r1,c2), both bank 5 → cycle 1: bank 5 gets port 0 data, busy = 1, in_ready = 0. Cycle 2: bank 5 gets (r1,c2). Cycle 3: in_ready = 1.
- **Eight-way conflict.** All 8 ports target bank 0 → exactly 8 consecutive cycles of buf_we[0] = 1, in port order. Ninth cycle: IDLE. conflict_count = 28 with NBA_STATS_EN.
- **Bank stall.** bank_busy[5] = 1 for 3 cycles against an entry to bank 5 → no write for 3 cycles, written the cycle after release; other banks are unaffected.
- **Backpressure.** New group presented while busy = 1 → not captured; the same group re-presented after in_ready = 1 is written exactly once.
- **Reset mid-drain.** reset_n low during DRAIN → all buf_we = 0 and busy = 0 immediately; after release, the previously pending entry is never written.
